// File: rtl/reg_scoreboard.sv
// Register-interlock scoreboard: one down-counter per architectural register
// tracks cycles until its pending result reaches the bypass path.
module reg_scoreboard #(
  parameter int NREG    = 32,
  parameter int RAW     = 5,
  parameter int MAX_LAT = 4,
  parameter int CW      = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           issue_valid_i,
  input  logic [RAW-1:0] issue_rs_i,
  input  logic [RAW-1:0] issue_rt_i,
  input  logic           issue_use_rs_i,
  input  logic           issue_use_rt_i,
  input  logic           issue_wr_i,
  input  logic [RAW-1:0] issue_rd_i,
  input  logic [CW-1:0]  issue_lat_i,
  input  logic           flush_i,
  output logic           stall_o,
  output logic           fwd_rs_o,
  output logic           fwd_rt_o,
  output logic [RAW:0]   busy_cnt_o
);

  logic [CW-1:0] pend     [NREG];
  logic [CW-1:0] pend_nxt [NREG];
  logic [RAW:0]  busy_nxt;
  logic [CW-1:0] rs_pend;
  logic [CW-1:0] rt_pend;
  logic          hz_rs;
  logic          hz_rt;
  logic          accept;

  function automatic logic [CW-1:0] clamp_lat(input logic [CW-1:0] lat);
    if (int'(lat) > MAX_LAT) return CW'(MAX_LAT);
    return lat;
  endfunction

  // Register 0 and out-of-range addresses always read as "nothing pending".
  assign rs_pend = (issue_rs_i != '0 && int'(issue_rs_i) < NREG) ? pend[issue_rs_i] : '0;
  assign rt_pend = (issue_rt_i != '0 && int'(issue_rt_i) < NREG) ? pend[issue_rt_i] : '0;

  assign hz_rs    = issue_use_rs_i && (issue_rs_i != '0) && (rs_pend >= CW'(2));
  assign hz_rt    = issue_use_rt_i && (issue_rt_i != '0) && (rt_pend >= CW'(2));
  assign stall_o  = issue_valid_i && !flush_i && (hz_rs || hz_rt);
  assign fwd_rs_o = issue_use_rs_i && (issue_rs_i != '0) && (rs_pend == CW'(1));
  assign fwd_rt_o = issue_use_rt_i && (issue_rt_i != '0) && (rt_pend == CW'(1));
  assign accept   = issue_valid_i && !flush_i && !stall_o && issue_wr_i && (issue_rd_i != '0);

  // The accept write overrides the decrement, so a younger producer wins WAW.
  always_comb begin
    busy_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_nxt[r] = (pend[r] != '0) ? pend[r] - CW'(1) : '0;
      if (r != 0 && accept && RAW'(r) == issue_rd_i)
        pend_nxt[r] = clamp_lat(issue_lat_i);
      if (r == 0)
        pend_nxt[r] = '0;
      if (pend_nxt[r] != '0)
        busy_nxt = busy_nxt + (RAW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      busy_cnt_o <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend[r] <= pend_nxt[r];
      busy_cnt_o <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: table of issue vectors with hand-computed
// stall/forward/busy results, plus an asynchronous reset sequence.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, use_rs, use_rt, wr, flush;
  logic [4:0] rs, rt, rd;
  logic [2:0] lat;
  logic       stall, fwd_rs, fwd_rt;
  logic [5:0] busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .RAW(5), .MAX_LAT(4), .CW(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(valid), .issue_rs_i(rs), .issue_rt_i(rt),
    .issue_use_rs_i(use_rs), .issue_use_rt_i(use_rt),
    .issue_wr_i(wr), .issue_rd_i(rd), .issue_lat_i(lat),
    .flush_i(flush),
    .stall_o(stall), .fwd_rs_o(fwd_rs), .fwd_rt_o(fwd_rt),
    .busy_cnt_o(busy)
  );

  typedef struct {
    logic       valid;
    logic       flush;
    logic       use_rs;
    logic [4:0] rs;
    logic       use_rt;
    logic [4:0] rt;
    logic       wr;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       e_stall;
    logic       e_frs;
    logic       e_frt;
    logic [5:0] e_busy;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input logic f,
                              input logic urs, input int a_rs,
                              input logic urt, input int a_rt,
                              input logic w, input int a_rd, input int l,
                              input logic es, input logic efs, input logic eft,
                              input int eb);
    vec_t t;
    t.valid = v; t.flush = f;
    t.use_rs = urs; t.rs = 5'(a_rs);
    t.use_rt = urt; t.rt = 5'(a_rt);
    t.wr = w; t.rd = 5'(a_rd); t.lat = 3'(l);
    t.e_stall = es; t.e_frs = efs; t.e_frt = eft; t.e_busy = 6'(eb);
    return t;
  endfunction

  task automatic check1(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid = t.valid; flush = t.flush;
    use_rs = t.use_rs; rs = t.rs;
    use_rt = t.use_rt; rt = t.rt;
    wr = t.wr; rd = t.rd; lat = t.lat;
  endtask

  // Inputs change just after a rising edge; combinational outputs are checked
  // at the falling edge and busy just after the following rising edge.
  task automatic step(input vec_t t, input int idx);
    drive(t);
    @(negedge clk);
    check1($sformatf("v%0d stall", idx),  {5'd0, stall},  {5'd0, t.e_stall});
    check1($sformatf("v%0d fwd_rs", idx), {5'd0, fwd_rs}, {5'd0, t.e_frs});
    check1($sformatf("v%0d fwd_rt", idx), {5'd0, fwd_rt}, {5'd0, t.e_frt});
    @(posedge clk); #1;
    check1($sformatf("v%0d busy", idx), busy, t.e_busy);
  endtask

  initial begin
    //          v  f  urs rs urt rt w  rd lat  stl frs frt busy
    vecs[0]  = mk(1, 0, 0, 0,  0, 0,  1, 8,  2,  0, 0, 0, 1); // load r8
    vecs[1]  = mk(1, 0, 1, 8,  0, 0,  1, 10, 3,  1, 0, 0, 1); // load-use stall, no write
    vecs[2]  = mk(1, 0, 1, 8,  0, 0,  1, 10, 3,  0, 1, 0, 1); // forward, accept r10
    vecs[3]  = mk(1, 0, 0, 0,  1, 8,  0, 0,  0,  0, 0, 0, 1); // r8 in regfile
    vecs[4]  = mk(1, 0, 0, 0,  0, 0,  1, 3,  1,  0, 0, 0, 2); // ALU r3, two pending
    vecs[5]  = mk(1, 0, 1, 3,  1, 3,  0, 0,  0,  0, 1, 1, 0); // both forward
    vecs[6]  = mk(1, 0, 0, 0,  0, 0,  1, 9,  7,  0, 0, 0, 1); // lat 7 clamps to 4
    vecs[7]  = mk(1, 0, 1, 9,  0, 0,  0, 0,  0,  1, 0, 0, 1);
    vecs[8]  = mk(1, 0, 1, 9,  0, 0,  0, 0,  0,  1, 0, 0, 1);
    vecs[9]  = mk(1, 0, 1, 9,  0, 0,  0, 0,  0,  1, 0, 0, 1);
    vecs[10] = mk(1, 0, 1, 9,  0, 0,  0, 0,  0,  0, 1, 0, 0);
    vecs[11] = mk(1, 0, 0, 0,  0, 0,  1, 4,  4,  0, 0, 0, 1); // WAW older
    vecs[12] = mk(1, 0, 0, 0,  0, 0,  1, 4,  1,  0, 0, 0, 1); // WAW younger shorter
    vecs[13] = mk(1, 0, 1, 4,  0, 0,  1, 0,  3,  0, 1, 0, 0); // write to r0 ignored
    vecs[14] = mk(1, 1, 1, 0,  1, 0,  1, 6,  3,  0, 0, 0, 0); // flushed accept
    vecs[15] = mk(1, 0, 1, 7,  0, 0,  1, 7,  3,  0, 0, 0, 1); // rs == rd, old counter
    vecs[16] = mk(1, 0, 1, 7,  0, 0,  1, 7,  1,  1, 0, 0, 1); // stalled write dropped
    vecs[17] = mk(1, 0, 1, 7,  0, 0,  0, 0,  0,  1, 0, 0, 1);
    vecs[18] = mk(1, 0, 0, 0,  1, 7,  0, 0,  0,  0, 0, 1, 0);
    vecs[19] = mk(1, 0, 0, 0,  0, 0,  1, 5,  3,  0, 0, 0, 1);
    vecs[20] = mk(1, 1, 1, 5,  0, 0,  0, 0,  0,  0, 0, 0, 1); // flush masks stall
    vecs[21] = mk(0, 0, 1, 5,  0, 0,  0, 0,  0,  0, 0, 0, 1); // invalid masks stall
    vecs[22] = mk(0, 0, 1, 5,  0, 0,  0, 0,  0,  0, 1, 0, 0); // fwd ignores valid

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset busy", busy, 6'd0);
    check1("reset stall", {5'd0, stall}, 6'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) step(vecs[i], i);

    // Mid-run asynchronous reset with r5 pending at 3.
    step(mk(1, 0, 0, 0, 0, 0, 1, 5, 3, 0, 0, 0, 1), 100);
    drive(mk(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check1("pre-reset stall", {5'd0, stall}, 6'd1);
    rst = 1'b1;
    #1;
    check1("async reset busy", busy, 6'd0);
    check1("async reset stall", {5'd0, stall}, 6'd0);
    check1("async reset fwd_rs", {5'd0, fwd_rs}, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("post-reset stall", {5'd0, stall}, 6'd0);
    check1("post-reset fwd_rs", {5'd0, fwd_rs}, 6'd0);
    @(posedge clk); #1;
    check1("post-reset busy", busy, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
